// File: rtl/mem_responder.sv
// Byte-wide memory responder: decodes the cache memory bus into a byte RAM
// or an I/O window with TX/RX console FIFOs, a status register and a halt flag.
module mem_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [31:0] addr_in,
    input  logic        r_nw_in,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halted,
    output logic        tx_overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam int PW    = FIFO_DEPTH_LOG + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [7:0] ram    [0:(1 << RAM_ADDR_WIDTH)-1];
    logic [7:0] tx_mem [0:DEPTH-1];
    logic [7:0] rx_mem [0:DEPTH-1];

    logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic          prev_io0_read;

    logic                      io_sel;
    logic [2:0]                io_off;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic                      bus_io0_rd;
    logic                      tx_empty, tx_full, rx_empty, rx_full;
    logic                      tx_push_req, tx_push, tx_pop;
    logic                      rx_push, rx_pop, ram_we, halt_wr;
    logic [7:0]                rx_head, status;
    logic                      unused_addr_hi;

    assign io_sel         = (addr_in[17:16] == 2'b11);
    assign io_off         = addr_in[2:0];
    assign ram_addr       = addr_in[RAM_ADDR_WIDTH-1:0];
    assign unused_addr_hi = ^addr_in[31:18];

    assign bus_io0_rd = io_sel && r_nw_in && (io_off == 3'd0);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[PW-1] != tx_rd_ptr[PW-1]) &&
                      (tx_wr_ptr[PW-2:0] == tx_rd_ptr[PW-2:0]);
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[PW-1] != rx_rd_ptr[PW-1]) &&
                      (rx_wr_ptr[PW-2:0] == rx_rd_ptr[PW-2:0]);

    assign tx_pop      = rdy && !tx_empty && tx_ready;
    assign tx_push_req = rdy && io_sel && !r_nw_in && (io_off == 3'd0);
    // A same-cycle drain frees the slot, so a full FIFO still accepts the byte.
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    // The cache parks on a read while idle; only the first cycle of a run pops.
    assign rx_pop   = rdy && bus_io0_rd && !prev_io0_read && !rx_empty;
    assign rx_ready = rdy && !rx_full;
    assign rx_push  = rx_valid && rx_ready;

    assign ram_we  = rdy && !io_sel && !r_nw_in;
    assign halt_wr = rdy && io_sel && !r_nw_in && (io_off == 3'd4);

    assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[PW-2:0]];
    assign status  = {6'b0, !rx_empty, tx_full};

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr[PW-2:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[PW-2:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr     <= '0;
            tx_rd_ptr     <= '0;
            rx_wr_ptr     <= '0;
            rx_rd_ptr     <= '0;
            prev_io0_read <= 1'b0;
            halted        <= 1'b0;
            tx_overflow   <= 1'b0;
            data_out      <= 8'h00;
        end else if (rdy) begin
            prev_io0_read <= bus_io0_rd;
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            if (tx_push_req && !tx_push) tx_overflow <= 1'b1;
            if (halt_wr) halted <= 1'b1;
            if (r_nw_in) begin
                if (!io_sel) begin
                    data_out <= ram[ram_addr];
                end else begin
                    case (io_off)
                        3'd0: if (!prev_io0_read) data_out <= rx_head;
                        3'd4: data_out <= status;
                        default: data_out <= 8'h00;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory responder at the far end of the cache's memory port. It decodes the address/read-not-write/data bus driven by the cache into a single-port byte RAM or a small memory-mapped I/O window. The I/O window holds a TX byte FIFO (console output), an RX byte FIFO (console input), a status register and a sticky halt flag. It sits between the cache's memory pins and the board-level RAM/UART glue, and has no stall path: every bus cycle is accepted.

## Interface
- `RAM_ADDR_WIDTH`, 17: RAM byte address bits; RAM holds 2^RAM_ADDR_WIDTH bytes.
- `FIFO_DEPTH_LOG`, 4: log2 depth of the TX and RX FIFOs (16 entries each).
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; low freezes all state.
- `addr_in` in 32: byte address from cache `addr_out`.
- `r_nw_in` in 1: 1 = read, 0 = write (`READ_SIGNAL`/`WRITE_SIGNAL`).
- `data_in` in 8: write byte from cache `data_out`.
- `data_out` out 8: read byte to cache `data_in`.
- `tx_data` out 8: head of TX FIFO.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: consumer accepts `tx_data` this cycle.
- `rx_data` in 8: incoming console byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: RX FIFO not full; combinational.
- `halted` out 1: sticky halt flag.
- `tx_overflow` out 1: sticky; a TX push was dropped.

## Operation
- Decode: `addr_in[17:16] == 2'b11` selects I/O, otherwise RAM at `addr_in[RAM_ADDR_WIDTH-1:0]`. Bits above 17 are ignored.
- RAM read: `data_out <= ram[a]`.
- RAM write: `ram[a] <= data_in`; `data_out` holds its value.
- I/O offset is `addr_in[2:0]`; other offsets read 0 and ignore writes.
- Offset 0, write: push `data_in` into the TX FIFO, one push per write cycle. If the FIFO is full (after this cycle's pop), drop the byte and set `tx_overflow`.
- Offset 0, read: `data_out <= RX head` (0 if empty).
  - Pop the RX FIFO only on a *new* access. A new access is any cycle where the previous enabled cycle was not a read of I/O offset 0. This is needed because the cache parks `addr_out` with `r_nw` = read while idle.
  - Offsets 1..3 of the same word read 0 and never pop.
- Offset 4, read: `data_out <= {6'b0, rx_nonempty, tx_full}`.
- Offset 4, write of any value: set `halted`.
- TX drain: when `tx_valid && tx_ready`, pop the TX head. Push and pop may occur in the same cycle. When the FIFO is full, the pop frees the slot and the push is accepted.
- RX fill: when `rx_valid && rx_ready`, push `rx_data`. An RX bus pop and a push may occur in the same cycle. On an empty FIFO, the popped/read value is 0 and the pushed byte stays.
- FIFO pointers are `FIFO_DEPTH_LOG+1` bits wide, with wrap bit for full/empty. Pointers wrap modulo 2*depth.
- `rdy` low:
  - No RAM write, no FIFO push/pop, no flag change.
  - `data_out` holds.
  - The new-access tracker holds.
  - `rx_ready` = 0.
  - `tx_valid` reflects FIFO state.

## Timing
- Reset (`rst_n` low, asynchronous), in effect immediately:
  - `data_out`, `tx_data` = 0.
  - `tx_valid`, `halted`, `tx_overflow` = 0.
  - FIFOs empty.
  - Tracker = "previous not I/O-0 read".
  - `rx_ready` = 1 once `rdy` is high.
  - RAM contents are not reset.
- Read latency is 1 cycle: address presented before edge N gives `data_out` valid after edge N, stable until edge N+1.
- Write takes effect at the edge. A RAM read of the same address on the next cycle returns the new byte.
- `tx_valid`/`tx_data` update at the edge after a push into an empty FIFO. There is no combinational bypass.
- `rx_ready` drops in the cycle after the 16th un-popped push.
- Reset mid-stream discards FIFO contents and any in-flight byte. A 4-byte cache access interrupted by reset is not completed.

## Test plan
- **RAM byte round trip.** Write 0xEF, 0xBE, 0xAD, 0xDE to 0x00100–0x00103, then read 0x00100–0x00103 on consecutive cycles. Required: `data_out` = EF, BE, AD, DE, each one cycle after its address. 0x30100 still decodes as I/O (offset 0).
- **TX full and overflow.** 17 consecutive writes to 0x30000 (values 0..16) with `tx_ready` = 0. Required: `tx_valid` = 1, status read = 0x01, `tx_overflow` = 1. Then `tx_ready` = 1 drains 0..15 in order and `tx_valid` falls after the 16th pop.
- **RX single pop on parked address.** Push 0x41, 0x42 via `rx_valid`, then hold `addr_in` = 0x30000 with read for 5 cycles. Required: `data_out` = 0x41 for all 5 cycles and only one pop. Moving to 0x30004 then back to 0x30000 returns 0x42. A further re-access returns 0.
- **Simultaneous events.** TX full with push and `tx_ready` in the same cycle: the byte is accepted and there is no overflow. RX empty with bus pop and `rx_valid` in the same cycle: `data_out` = 0 and the byte is later readable.
- **Halt and rdy freeze.** With `rdy` = 0, write to 0x30004 and 0x00010. Required: `halted` stays 0 and RAM is unchanged. With `rdy` = 1, a write to 0x30004 sets `halted` = 1, and it stays 1 until `rst_n` is low.
- **Async reset mid-operation.** Pulse `rst_n` low between clock edges with 3 TX bytes queued. Required: `tx_valid`, `data_out`, `halted` and `tx_overflow` clear immediately with no clock, and earlier RAM writes still read back.
